irq_gen: RTL and testbench

- Interrupt generator downstream of the interrupt-collapsing stage.
- Latches the single-cycle `send_irq` pulses as a sticky pending flag.
- Applies host enable and a programmable moderation hold-off.
- Drives the Virtex-5 PCIe endpoint MSI request/ready handshake: at most one outstanding MSI, and a minimum spacing between interrupts.

---
 rtl/irq_gen.sv | 92 +++++++++
 tb/tb_irq_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gen.sv
// irq_gen: MSI interrupt generator for the Virtex-5 PCIe endpoint.
// Latches collapsed send_irq pulses as a sticky pending flag, gates them with
// the host enables, drives the MSI request/ready handshake with at most one
// outstanding request, and enforces a programmable hold-off between MSIs.
module irq_gen #(
    parameter int unsigned HOLDOFF_W  = 16,
    parameter logic [7:0]  MSI_VECTOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send_irq,
    input  logic                 irq_en,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    input  logic                 cfg_interrupt_msienable,
    input  logic                 cfg_interrupt_rdy_n,
    output logic                 cfg_interrupt_n,
    output logic [7:0]           cfg_interrupt_di,
    output logic                 irq_pending,
    output logic [31:0]          irq_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLDOFF
    } state_t;

    state_t               state, state_nxt;
    logic [HOLDOFF_W-1:0] timer, timer_nxt;
    logic                 pend_nxt;
    logic                 int_n_nxt;
    logic [31:0]          count_nxt;

    assign cfg_interrupt_di = MSI_VECTOR;

    // Next-state and registered-output logic; a new send_irq always wins over
    // the clear that happens when the request is launched.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        int_n_nxt = cfg_interrupt_n;
        count_nxt = irq_count;
        pend_nxt  = irq_pending | send_irq;
        case (state)
            IDLE: begin
                if (irq_pending && irq_en && cfg_interrupt_msienable) begin
                    state_nxt = REQ;
                    int_n_nxt = 1'b0;
                    pend_nxt  = send_irq;
                end
            end
            REQ: begin
                // Request is held until acknowledged, regardless of enables.
                if (!cfg_interrupt_rdy_n) begin
                    int_n_nxt = 1'b1;
                    count_nxt = irq_count + 32'd1;
                    timer_nxt = holdoff_cycles;
                    state_nxt = (holdoff_cycles != '0) ? HOLDOFF : IDLE;
                end
            end
            HOLDOFF: begin
                if (timer <= HOLDOFF_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - HOLDOFF_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                int_n_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            cfg_interrupt_n <= 1'b1;
            irq_pending     <= 1'b0;
            irq_count       <= '0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            cfg_interrupt_n <= int_n_nxt;
            irq_pending     <= pend_nxt;
            irq_count       <= count_nxt;
        end
    end

endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen: self-checking bench for irq_gen. A timestamp-based reference
// model (earliest cycle a new MSI may launch) is advanced on every clock and
// compared after each edge; a vector table and directed sequences cover the
// multi-cycle corner cases, followed by randomized stimulus.
module tb_irq_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_irq;
    logic        irq_en;
    logic [15:0] holdoff_cycles;
    logic        cfg_interrupt_msienable;
    logic        cfg_interrupt_rdy_n;
    logic        cfg_interrupt_n;
    logic [7:0]  cfg_interrupt_di;
    logic        irq_pending;
    logic [31:0] irq_count;

    localparam logic [7:0] VEC = 8'hA5;

    irq_gen #(.HOLDOFF_W(16), .MSI_VECTOR(VEC)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .send_irq                (send_irq),
        .irq_en                  (irq_en),
        .holdoff_cycles          (holdoff_cycles),
        .cfg_interrupt_msienable (cfg_interrupt_msienable),
        .cfg_interrupt_rdy_n     (cfg_interrupt_rdy_n),
        .cfg_interrupt_n         (cfg_interrupt_n),
        .cfg_interrupt_di        (cfg_interrupt_di),
        .irq_pending             (irq_pending),
        .irq_count               (irq_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    bit          m_pend;
    bit          m_req;
    logic [31:0] m_cnt;
    longint      m_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_pend = 0; m_req = 0; m_cnt = '0; m_ok = 0;
        end else if (m_req) begin
            if (!cfg_interrupt_rdy_n) begin
                m_req = 0;
                m_cnt = m_cnt + 1;
                m_ok  = cyc + longint'(holdoff_cycles) + 1;
            end
            if (send_irq) m_pend = 1;
        end else if (m_pend && irq_en && cfg_interrupt_msienable && cyc >= m_ok) begin
            m_req  = 1;
            m_pend = send_irq;
        end else if (send_irq) begin
            m_pend = 1;
        end
    endtask

    task automatic check_model();
        check("model_cfg_n", {31'b0, cfg_interrupt_n}, {31'b0, !m_req});
        check("model_pending", {31'b0, irq_pending}, {31'b0, m_pend});
        check("model_count", irq_count, m_cnt);
        check("msi_data", {24'b0, cfg_interrupt_di}, {24'b0, VEC});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        check_model();
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (cfg_interrupt_n !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check("req_within_bound", {31'b0, cfg_interrupt_n}, 32'd0);
    endtask

    typedef struct {
        logic        rst_n, send, en, ms, rdy_n;
        logic [15:0] hold;
        logic        exp_n, exp_pend;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t   tbl[15];
    int     ack_cyc, fall_cyc;
    bit     acked2;
    logic [31:0] base_cnt;

    initial begin
        rst_n = 0; send_irq = 0; irq_en = 0; holdoff_cycles = '0;
        cfg_interrupt_msienable = 0; cfg_interrupt_rdy_n = 1;

        //          rst send en ms rdy hold    n pend cnt
        tbl[0]  = '{0, 0, 0, 0, 1, 16'd0, 1, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 16'd0, 1, 1, 0};
        tbl[2]  = '{1, 0, 1, 1, 1, 16'd0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 1, 1, 16'd0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 1, 0, 16'd0, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 0, 16'd0, 1, 1, 1};
        tbl[6]  = '{1, 0, 0, 1, 1, 16'd0, 1, 1, 1};
        tbl[7]  = '{1, 0, 1, 0, 1, 16'd0, 1, 1, 1};
        tbl[8]  = '{1, 1, 1, 1, 1, 16'd0, 0, 1, 1};
        tbl[9]  = '{1, 0, 1, 1, 0, 16'd2, 1, 1, 2};
        tbl[10] = '{1, 0, 1, 1, 1, 16'd0, 1, 1, 2};
        tbl[11] = '{1, 0, 1, 1, 1, 16'd0, 1, 1, 2};
        tbl[12] = '{1, 0, 1, 1, 1, 16'd0, 0, 0, 2};
        tbl[13] = '{0, 0, 1, 1, 1, 16'd0, 1, 0, 0};
        tbl[14] = '{1, 0, 1, 1, 0, 16'd0, 1, 0, 0};

        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n; send_irq = tbl[i].send; irq_en = tbl[i].en;
            cfg_interrupt_msienable = tbl[i].ms; cfg_interrupt_rdy_n = tbl[i].rdy_n;
            holdoff_cycles = tbl[i].hold;
            step();
            check("tbl_cfg_n", {31'b0, cfg_interrupt_n}, {31'b0, tbl[i].exp_n});
            check("tbl_pending", {31'b0, irq_pending}, {31'b0, tbl[i].exp_pend});
            check("tbl_count", irq_count, tbl[i].exp_cnt);
        end

        // Basic delivery: pulse -> request two edges later, ack 3 cycles after.
        rst_n = 0; send_irq = 0; cfg_interrupt_rdy_n = 1; holdoff_cycles = '0;
        irq_en = 1; cfg_interrupt_msienable = 1;
        step(); rst_n = 1;
        repeat (9) step();
        send_irq = 1; step(); send_irq = 0;
        step();
        check("basic_latency", {31'b0, cfg_interrupt_n}, 32'd0);
        repeat (2) step();
        cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;
        check("basic_release", {31'b0, cfg_interrupt_n}, 32'd1);
        check("basic_count", irq_count, 32'd1);
        check("basic_pending", {31'b0, irq_pending}, 32'd0);

        // Collapsing and moderation with holdoff=100.
        holdoff_cycles = 16'd100;
        send_irq = 1; step(); send_irq = 0;
        wait_req(10);
        step();
        base_cnt = m_cnt;
        ack_cyc = -1; fall_cyc = -1; acked2 = 0;
        for (int i = 0; i < 300; i++) begin
            send_irq = (i % 10 == 0) && (i < 50);
            cfg_interrupt_rdy_n = 1;
            if (i == 1) cfg_interrupt_rdy_n = 0;
            if (fall_cyc >= 0 && !acked2) begin
                cfg_interrupt_rdy_n = 0;
                acked2 = 1;
            end
            step();
            if (i == 1) ack_cyc = cyc;
            if (i > 1 && fall_cyc < 0 && cfg_interrupt_n == 1'b0) fall_cyc = cyc;
        end
        send_irq = 0; cfg_interrupt_rdy_n = 1;
        check("holdoff_spacing", 32'(fall_cyc - ack_cyc), 32'd101);
        check("collapse_count", irq_count, base_cnt + 32'd2);

        // Enable gating: irq_en, then msienable.
        holdoff_cycles = '0;
        for (int g = 0; g < 2; g++) begin
            if (g == 0) irq_en = 0; else cfg_interrupt_msienable = 0;
            send_irq = 1; step(); send_irq = 0;
            repeat (500) step();
            check("gate_pending_held", {31'b0, irq_pending}, 32'd1);
            check("gate_no_request", {31'b0, cfg_interrupt_n}, 32'd1);
            irq_en = 1; cfg_interrupt_msienable = 1;
            step();
            check("gate_release_latency", {31'b0, cfg_interrupt_n}, 32'd0);
            cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;
        end

        // Drop irq_en while the request waits for acknowledge.
        send_irq = 1; step(); send_irq = 0;
        wait_req(5);
        base_cnt = m_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) irq_en = 0;
            step();
        end
        check("drop_en_held", {31'b0, cfg_interrupt_n}, 32'd0);
        cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;
        check("drop_en_count", irq_count, base_cnt + 32'd1);
        irq_en = 1;

        // Set wins over the launch-edge clear; second MSI follows hold-off.
        holdoff_cycles = 16'd3;
        irq_en = 0; send_irq = 1; step();
        irq_en = 1; send_irq = 1; step(); send_irq = 0;
        check("set_wins_pending", {31'b0, irq_pending}, 32'd1);
        check("set_wins_request", {31'b0, cfg_interrupt_n}, 32'd0);
        cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;
        ack_cyc = cyc;
        wait_req(10);
        check("set_wins_spacing", 32'(cyc - ack_cyc), 32'd4);
        cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;

        // Reset while a request is outstanding; late ack is ignored.
        holdoff_cycles = '0;
        repeat (5) step();
        send_irq = 1; step(); send_irq = 0;
        wait_req(5);
        rst_n = 0; step();
        check("rst_req_cfg_n", {31'b0, cfg_interrupt_n}, 32'd1);
        check("rst_req_count", irq_count, 32'd0);
        check("rst_req_pending", {31'b0, irq_pending}, 32'd0);
        rst_n = 1; cfg_interrupt_rdy_n = 0; step(); cfg_interrupt_rdy_n = 1;
        check("rst_late_ack", irq_count, 32'd0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rst_n                   = ($urandom_range(0, 299) != 0);
            send_irq                = ($urandom_range(0, 7) == 0);
            irq_en                  = ($urandom_range(0, 9) != 0);
            cfg_interrupt_msienable = ($urandom_range(0, 9) != 0);
            cfg_interrupt_rdy_n     = ($urandom_range(0, 3) != 0);
            holdoff_cycles          = 16'($urandom_range(0, 6));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
